// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main controller for the multicycle RV32I core. Steps each instruction
// through a fixed set of states and drives the shared ALU, the memory port,
// the instruction register and the register file. Memory accesses wait on
// the mem_ready handshake.
//
// Handshake: a memory access is presented while the controller sits in
// FETCH, MEMREAD or MEMWRITE. It completes in the cycle where mem_ready is
// high. The controller holds its state, and therefore the address and
// strobes, until that cycle. Registers are enabled only in that cycle.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   op           instruction opcode (IR[6:0])
//   zero         ALU Zero flag, sampled in BEQ
//   mem_ready    current memory access completes this cycle
//   PCWrite      PC register enable
//   AdrSrc       memory address select (0=PC, 1=ALUOut)
//   MemWrite     data memory write strobe
//   IRWrite      instruction/OldPC register enable
//   ResultSrc    result mux (00=ALUOut, 01=Data, 10=ALUResult)
//   ALUSrcA      ALU A mux (00=PC, 01=OldPC, 10=rs1)
//   ALUSrcB      ALU B mux (00=rs2, 01=ImmExt, 10=constant 4)
//   ALUOp        ALU decoder control (00=add, 01=sub, 10=funct)
//   RegWrite     register file write enable
//   ImmSrc       immediate format, combinational from op
//   illegal_op   pulse: unsupported opcode seen in DECODE
//   state_dbg    current state encoding
//
// All outputs are decoded combinationally from the state register and the
// current inputs. During reset the state is FETCH, so the outputs show the
// FETCH values.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    // State entered on reset. It must remain FETCH (0).
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Mux select encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] A_PC       = 2'b00;
    localparam logic [1:0] A_OLDPC    = 2'b01;
    localparam logic [1:0] A_RS1      = 2'b10;
    localparam logic [1:0] B_RS2      = 2'b00;
    localparam logic [1:0] B_IMM      = 2'b01;
    localparam logic [1:0] B_FOUR     = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    state_e state_q;
    state_e state_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTER;
                    OP_ITYPE: state_d = S_EXECUTEI;
                    OP_JAL:   state_d = S_JAL;
                    OP_BEQ:   state_d = S_BEQ;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            // Codes 11..15 are never reached; recover through FETCH.
            default:    state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    logic       legal_op;
    logic [1:0] imm_sel;

    always_comb begin
        legal_op = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_ITYPE, OP_JAL, OP_BEQ: legal_op = 1'b1;
            default:                  legal_op = 1'b0;
        endcase
    end

    always_comb begin
        imm_sel = 2'b00;
        case (op)
            OP_LOAD, OP_ITYPE: imm_sel = 2'b00;
            OP_STORE:          imm_sel = 2'b01;
            OP_BEQ:            imm_sel = 2'b10;
            OP_JAL:            imm_sel = 2'b11;
            default:           imm_sel = 2'b00;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = A_PC;
        ALUSrcB    = B_RS2;
        ALUOp      = ALU_ADD;
        RegWrite   = 1'b0;
        ImmSrc     = imm_sel;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read, so both
                // registers load together when the read completes.
                ALUSrcA   = A_PC;
                ALUSrcB   = B_FOUR;
                ALUOp     = ALU_ADD;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is precomputed into ALUOut.
                ALUSrcA    = A_OLDPC;
                ALUSrcB    = B_IMM;
                ALUOp      = ALU_ADD;
                illegal_op = ~legal_op;
            end
            S_MEMADR: begin
                ALUSrcA = A_RS1;
                ALUSrcB = B_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays high while waiting; memory commits only on
                // the mem_ready cycle.
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = A_RS1;
                ALUSrcB = B_RS2;
                ALUOp   = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = A_RS1;
                ALUSrcB = B_IMM;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 as the link
                // value, written back in ALUWB.
                ALUSrcA   = A_OLDPC;
                ALUSrcB   = B_FOUR;
                ALUOp     = ALU_ADD;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = A_RS1;
                ALUSrcB   = B_RS2;
                ALUOp     = ALU_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = zero;
            end
            default: begin
                // Unreachable codes drive everything low.
                ImmSrc = 2'b00;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Bench for multicycle_ctrl. Each instruction is expanded into its expected
// per-cycle trace: state code, planned mem_ready/zero and the control word.
// The trace length follows the instruction class and the number of memory
// wait cycles. The DUT is stepped through the trace and compared at every
// cycle. The number of PCWrite pulses per instruction is also checked.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state_dbg;

    multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegWrite  (RegWrite),
        .ImmSrc    (ImmSrc),
        .illegal_op(illegal_op),
        .state_dbg (state_dbg)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ scoreboard
    // Expected word: {state[3:0], PCWrite, AdrSrc, MemWrite, IRWrite,
    //                 ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0],
    //                 RegWrite, ImmSrc[1:0], illegal_op}
    logic [19:0] exp_q[$];
    logic        mr_q[$];
    logic        zr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] dut_word();
        return {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, RegWrite, ImmSrc, illegal_op};
    endfunction

    // --------------------------------------------------------- reference model
    // Instruction classes: 0=load 1=store 2=R 3=I 4=jal 5=beq 6=illegal
    function automatic int op_class(input logic [6:0] o);
        if (o == OP_LOAD)  return 0;
        if (o == OP_STORE) return 1;
        if (o == OP_RTYPE) return 2;
        if (o == OP_ITYPE) return 3;
        if (o == OP_JAL)   return 4;
        if (o == OP_BEQ)   return 5;
        return 6;
    endfunction

    // Control word for a given state code straight from the state table.
    function automatic logic [15:0] ref_outs(input int st, input logic [6:0] o,
                                             input logic z, input logic mr);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, aop, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; aop = 0;
        case (op_class(o))
            1:       imm = 2'b01;
            5:       imm = 2'b10;
            4:       imm = 2'b11;
            default: imm = 2'b00;
        endcase
        case (st)
            0:  begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin sa = 1; sb = 1; ill = (op_class(o) == 6); end
            2:  begin sa = 2; sb = 1; end
            3:  begin adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; sb = 0; aop = 2; end
            8:  begin sa = 2; sb = 1; aop = 2; end
            7:  begin rw = 1; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; aop = 1; pcw = z; end
            default: imm = 0;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, imm, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_step(input int st, input logic [6:0] o, input logic mr, input logic z);
        exp_q.push_back({4'(st), ref_outs(st, o, z, mr)});
        mr_q.push_back(mr);
        zr_q.push_back(z);
    endtask

    // ------------------------------------------------------------- drivers
    // Build the trace of one instruction, then step the DUT through it.
    // Starts with the DUT in FETCH, called just before a falling edge.
    task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic zb);
        logic [19:0] e;
        int          pcw_seen;
        int          pcw_exp;
        int          cls;
        cls = op_class(o);
        for (int i = 0; i < fw; i++) add_step(0, o, 1'b0, rbit());
        add_step(0, o, 1'b1, rbit());
        add_step(1, o, rbit(), rbit());
        case (cls)
            0: begin
                add_step(2, o, rbit(), rbit());
                for (int i = 0; i < mw; i++) add_step(3, o, 1'b0, rbit());
                add_step(3, o, 1'b1, rbit());
                add_step(4, o, rbit(), rbit());
            end
            1: begin
                add_step(2, o, rbit(), rbit());
                for (int i = 0; i < mw; i++) add_step(5, o, 1'b0, rbit());
                add_step(5, o, 1'b1, rbit());
            end
            2: begin add_step(6, o, rbit(), rbit()); add_step(7, o, rbit(), rbit()); end
            3: begin add_step(8, o, rbit(), rbit()); add_step(7, o, rbit(), rbit()); end
            4: begin add_step(9, o, rbit(), rbit()); add_step(7, o, rbit(), rbit()); end
            5: add_step(10, o, rbit(), zb);
            default: ;
        endcase
        pcw_exp = 1 + ((cls == 4) ? 1 : 0) + ((cls == 5 && zb) ? 1 : 0);
        pcw_seen = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            op        = o;
            mem_ready = mr_q.pop_front();
            zero      = zr_q.pop_front();
            #1;
            e = exp_q.pop_front();
            check_eq($sformatf("op=%b st=%0d", o, e[19:16]), dut_word(), e);
            pcw_seen += int'(PCWrite);
        end
        // Next instruction begins after the final edge of this one.
        check_eq($sformatf("pcw_count op=%b", o), 20'(pcw_seen), 20'(pcw_exp));
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic [6:0] rnd_op;
        logic [6:0] legal_ops[6];
        legal_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ};

        // Reset with mem_ready high shows FETCH outputs.
        rst_n = 1'b0; op = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
        #2;
        check_eq("reset_outputs", dut_word(), {4'd0, ref_outs(0, OP_RTYPE, 1'b0, 1'b1)});
        check_eq("reset_irw_pcw", 20'({IRWrite, PCWrite}), 20'h3);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", 20'(state_dbg), 20'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // Directed instructions
        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_LOAD,  2, 3, 1'b0);
        run_instr(OP_STORE, 0, 0, 1'b0);
        run_instr(OP_BEQ,   0, 0, 1'b1);
        run_instr(OP_BEQ,   0, 0, 1'b0);
        run_instr(OP_JAL,   0, 0, 1'b0);
        run_instr(OP_ITYPE, 1, 0, 1'b0);
        run_instr(7'b0000000, 0, 0, 1'b0);
        run_instr(OP_STORE, 1, 2, 1'b1);

        // Random instructions
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) rnd_op = 7'($urandom);
            else rnd_op = legal_ops[$urandom_range(0, 5)];
            run_instr(rnd_op, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        end

        // Reset during MEMWRITE: strobe must drop at once.
        @(negedge clk);
        op = OP_STORE; mem_ready = 1'b1; zero = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_eq("memwrite_before_rst", dut_word(), {4'd5, ref_outs(5, OP_STORE, 1'b0, 1'b0)});
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("memwrite_in_rst", dut_word(), {4'd0, ref_outs(0, OP_STORE, 1'b0, 1'b0)});
        check_eq("memwrite_low", 20'(MemWrite), 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(OP_RTYPE, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
